icache: RTL and testbench

Direct-mapped, read-only instruction cache on the cache side of the datapath/cache instruction port. It answers the pipeline's fetch requests (imemREN/imemaddr) with a single-cycle hit (ihit/imemload). On a miss it issues a one-word read to the memory controller (iREN/iaddr/iwait/iload), fills the frame and then hits. It sits between the datapath fetch stage and the memory controller's instruction port.

---
 rtl/icache.sv | 120 ++++++++++++
 tb/tb_icache.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// ============================================================================
//  Module   : icache
//  Purpose  : Direct-mapped, read-only instruction cache. Serves datapath
//             fetches with a zero-latency hit; on a miss it performs a
//             one-word read from the memory controller, fills the frame
//             and then hits.
//  Ports    : CLK, nRST          clock (rising edge), async active-low reset
//             imemREN, imemaddr  datapath fetch request / byte address
//             ihit, imemload     hit flag / instruction word (0 on no hit)
//             iREN, iaddr        memory read request / word address
//             iwait, iload       memory busy / memory read data
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 32 - IDX - 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_miss_addr;
  logic [SETS-1:0]   r_valid;
  logic [TAGW-1:0]   r_tag  [SETS];
  logic [31:0]       r_data [SETS];

  logic [IDX-1:0]    w_index;
  logic [TAGW-1:0]   w_tag;
  logic [IDX-1:0]    w_miss_index;
  logic [TAGW-1:0]   w_miss_tag;
  logic              w_hit;
  logic              w_fill;
  logic              w_unused;

  assign w_index      = imemaddr[IDX+1:2];
  assign w_tag        = imemaddr[31:IDX+2];
  assign w_miss_index = r_miss_addr[IDX+1:2];
  assign w_miss_tag   = r_miss_addr[31:IDX+2];
  // Byte offset plays no part in a word-granular lookup.
  assign w_unused     = ^imemaddr[1:0];

  // Hits are only reported from IDLE so ihit and iREN are never both high.
  assign w_hit    = imemREN & r_valid[w_index] & (r_tag[w_index] == w_tag)
                    & (r_state == IDLE);
  assign ihit     = w_hit;
  assign imemload = w_hit ? r_data[w_index] : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= 32'h0;
    end else begin
      r_state <= w_next_state;
      // The refill always targets this latched address, so the datapath may
      // change or drop its request while the fill is in flight.
      if (r_state == IDLE && imemREN && !w_hit)
        r_miss_addr <= {imemaddr[31:2], 2'b00};
    end
  end

  always_comb begin
    w_next_state = r_state;
    iREN         = 1'b0;
    iaddr        = 32'h0;
    w_fill       = 1'b0;
    case (r_state)
      IDLE: begin
        if (imemREN && !w_hit)
          w_next_state = FETCH;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = r_miss_addr;
        if (!iwait) begin
          w_fill       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Valid bits are the only array state that needs reset; a reset during a
  // fill simply discards it because the valid bit is never set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_valid <= '0;
    else if (w_fill)
      r_valid[w_miss_index] <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_miss_index]  <= w_miss_tag;
      r_data[w_miss_index] <= iload;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
//  Module   : tb_icache
//  Purpose  : Self-checking bench for icache. A behavioural model records,
//             per set, which word address is resident; every fetch is
//             predicted as a hit (same-cycle data) or a miss (W+1 cycles of
//             iREN at the word address, then a hit).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache;

  localparam int SETS = 16;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which word address each set currently holds.
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];

  icache #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h00000000: return 32'h8C010004;
      32'h00000004: return 32'h11111111;
      32'h00000044: return 32'h22222222;
      default:      return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endcase
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = int'(a[5:2]);
    return m_valid[s] && (m_word[s] == a[31:2]);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // One fetch of addr. On a miss memory waits w cycles; if wander is set the
  // datapath drops/changes its request during the fill.
  task automatic do_fetch(input logic [31:0] addr, input int w, input bit wander);
    logic [31:0] exp_d;
    exp_d    = memword(addr);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = $urandom_range(0, 1);
    iload    = $urandom;
    if (!model_hit(addr)) begin
      @(negedge CLK);
      check("miss_ihit", {31'b0, ihit}, 32'h0);
      check("miss_load", imemload, 32'h0);
      check("miss_iren0", {31'b0, iREN}, 32'h0);
      next_cycle();
      for (int k = 0; k <= w; k++) begin
        iwait = (k < w);
        iload = (k == w) ? exp_d : $urandom;
        if (wander) begin
          imemREN  = $urandom_range(0, 1);
          imemaddr = $urandom;
        end
        @(negedge CLK);
        check("fetch_iren", {31'b0, iREN}, 32'h1);
        check("fetch_iaddr", iaddr, {addr[31:2], 2'b00});
        check("fetch_ihit", {31'b0, ihit}, 32'h0);
        next_cycle();
      end
      m_valid[int'(addr[5:2])] = 1'b1;
      m_word[int'(addr[5:2])]  = addr[31:2];
      imemREN  = 1'b1;
      imemaddr = addr;
      iwait    = $urandom_range(0, 1);
      iload    = $urandom;
    end
    @(negedge CLK);
    check("hit_ihit", {31'b0, ihit}, 32'h1);
    check("hit_load", imemload, exp_d);
    check("hit_iren", {31'b0, iREN}, 32'h0);
    next_cycle();
  endtask

  task automatic idle_cycle();
    imemREN  = 1'b0;
    imemaddr = $urandom;
    iwait    = $urandom_range(0, 1);
    @(negedge CLK);
    check("idle_ihit", {31'b0, ihit}, 32'h0);
    check("idle_load", imemload, 32'h0);
    check("idle_iren", {31'b0, iREN}, 32'h0);
    check("idle_iaddr", iaddr, 32'h0);
    next_cycle();
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    #2;
    check("rst_ihit", {31'b0, ihit}, 32'h0);
    check("rst_load", imemload, 32'h0);
    check("rst_iren", {31'b0, iREN}, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    model_clear();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    nRST     = 1'b1;
    #1;
    apply_reset();

    // Cold miss with two wait cycles, then offset-ignored hit.
    do_fetch(32'h00000000, 2, 1'b0);
    idle_cycle();
    do_fetch(32'h00000002, 2, 1'b0);

    // Conflict eviction on set 1.
    do_fetch(32'h00000004, 1, 1'b0);
    do_fetch(32'h00000044, 0, 1'b0);
    do_fetch(32'h00000004, 2, 1'b0);
    do_fetch(32'h00000044, 1, 1'b0);

    // Request dropped and address changed mid-fill.
    do_fetch(32'h00000010, 3, 1'b1);
    do_fetch(32'h00000010, 0, 1'b0);

    // Reset during a fill discards everything.
    do_fetch(32'h00000000, 0, 1'b0);
    imemREN  = 1'b1;
    imemaddr = 32'h00000008;
    @(negedge CLK);
    check("pre_rst_miss", {31'b0, ihit}, 32'h0);
    next_cycle();
    iwait = 1'b1;
    @(negedge CLK);
    check("pre_rst_iren", {31'b0, iREN}, 32'h1);
    apply_reset();
    do_fetch(32'h00000000, 1, 1'b0);
    do_fetch(32'h00000008, 1, 1'b0);

    // Zero-wait memory, sequential reads from a clean cache.
    apply_reset();
    do_fetch(32'h00000000, 0, 1'b0);
    do_fetch(32'h00000004, 0, 1'b0);
    do_fetch(32'h00000008, 0, 1'b0);

    // Random traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      a = ({30'b0, 2'($urandom_range(0, 3))} << 12)
        | ({28'b0, 4'($urandom_range(0, 15))} << 2)
        | {30'b0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 4) == 0) idle_cycle();
      do_fetch(a, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
